// File: rtl/goertzel_bin_scheduler_if.sv
// Handshake between the Goertzel bin scheduler and the Goertzel magnitude manager:
// coefficient requests going one way, per-bin magnitude results coming back.
interface goertzel_bin_scheduler_if #(
    parameter int MAG_W = 16
);
    logic             request_trig;
    logic [15:0]      sin_out;
    logic [15:0]      cos_out;
    logic [4:0]       num_runs;
    logic [MAG_W-1:0] mag_in;
    logic             mag_rdy;

    // manager side
    modport master (
        output request_trig, mag_in, mag_rdy,
        input  sin_out, cos_out, num_runs
    );

    // scheduler side
    modport slave (
        input  request_trig, mag_in, mag_rdy,
        output sin_out, cos_out, num_runs
    );
endinterface

// File: rtl/goertzel_bin_scheduler.sv
// Serves sine/cosine coefficient pairs to the Goertzel manager, collects the per-bin
// magnitudes it returns, and reports the peak bin of each frame against a threshold.
module goertzel_bin_scheduler #(
    parameter int NUM_BINS = 16,
    parameter int BIN_BITS = 5,
    parameter int MAG_W    = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    goertzel_bin_scheduler_if.slave mgr,
    input  logic                    cfg_wr_en,
    input  logic [BIN_BITS-1:0]     cfg_wr_addr,
    input  logic [15:0]             cfg_sin,
    input  logic [15:0]             cfg_cos,
    input  logic [4:0]              cfg_num_bins,
    input  logic [MAG_W-1:0]        threshold,
    input  logic                    err_clr,
    input  logic [BIN_BITS-1:0]     rd_addr,
    output logic [MAG_W-1:0]        rd_mag,
    output logic [BIN_BITS-1:0]     peak_bin,
    output logic [MAG_W-1:0]        peak_mag,
    output logic                    detect,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt,
    output logic                    seq_err
);

    localparam int                  IDX_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [4:0]          MAX_RUNS = 5'(NUM_BINS);
    localparam logic [BIN_BITS-1:0] DEPTH    = BIN_BITS'(NUM_BINS);
    localparam logic [BIN_BITS-1:0] ONE_IDX  = BIN_BITS'(1);

    logic [15:0]         sin_tab [NUM_BINS];
    logic [15:0]         cos_tab [NUM_BINS];
    logic [MAG_W-1:0]    res_tab [NUM_BINS];

    logic [BIN_BITS-1:0] issue_idx;
    logic [BIN_BITS-1:0] result_idx;
    logic                outstanding;
    logic [4:0]          num_runs;
    logic [15:0]         sin_q;
    logic [15:0]         cos_q;
    logic [MAG_W-1:0]    run_mag;
    logic [BIN_BITS-1:0] run_bin;

    logic                runs_zero;
    logic                idle;
    logic [4:0]          runs_clamped;
    logic [BIN_BITS-1:0] run_last;
    logic                res_ok;
    logic                res_err;
    logic                req_ok;
    logic                req_err;
    logic                take_new;
    logic [MAG_W-1:0]    next_mag;
    logic [BIN_BITS-1:0] next_bin;

    assign mgr.sin_out  = sin_q;
    assign mgr.cos_out  = cos_q;
    assign mgr.num_runs = num_runs;

    assign runs_zero    = (num_runs == 5'd0);
    assign idle         = (issue_idx == '0) && (result_idx == '0) && !outstanding;
    assign runs_clamped = (cfg_num_bins > MAX_RUNS) ? MAX_RUNS : cfg_num_bins;
    assign run_last     = BIN_BITS'(num_runs - 5'd1);

    // A coincident result retires the outstanding request before the new request is judged.
    assign res_ok   = mgr.mag_rdy && outstanding && !runs_zero;
    assign res_err  = mgr.mag_rdy && !res_ok;
    assign req_ok   = mgr.request_trig && !runs_zero;
    assign req_err  = mgr.request_trig && (runs_zero || (outstanding && !res_ok));

    // Ties keep the earlier bin: a later bin must be strictly larger to win.
    assign take_new = (result_idx == '0) || (mgr.mag_in > run_mag);
    assign next_mag = take_new ? mgr.mag_in : run_mag;
    assign next_bin = take_new ? result_idx : run_bin;

    always_ff @(posedge sys_clk) begin
        if (cfg_wr_en && (cfg_wr_addr < DEPTH)) begin
            sin_tab[cfg_wr_addr[IDX_W-1:0]] <= cfg_sin;
            cos_tab[cfg_wr_addr[IDX_W-1:0]] <= cfg_cos;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                res_tab[i] <= '0;
            end
            rd_mag <= '0;
        end else begin
            if (res_ok) begin
                res_tab[result_idx[IDX_W-1:0]] <= mgr.mag_in;
            end
            rd_mag <= (rd_addr < DEPTH) ? res_tab[rd_addr[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            issue_idx   <= '0;
            result_idx  <= '0;
            outstanding <= 1'b0;
            num_runs    <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            run_mag     <= '0;
            run_bin     <= '0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            detect      <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            seq_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Index is stable the cycle before a request, so the manager sees the pre-increment pair.
            sin_q      <= sin_tab[issue_idx[IDX_W-1:0]];
            cos_q      <= cos_tab[issue_idx[IDX_W-1:0]];

            if (idle) begin
                num_runs <= runs_clamped;
            end

            if (req_ok) begin
                issue_idx   <= (issue_idx == run_last) ? '0 : issue_idx + ONE_IDX;
                outstanding <= 1'b1;
            end else if (res_ok) begin
                outstanding <= 1'b0;
            end

            if (res_ok) begin
                run_mag <= next_mag;
                run_bin <= next_bin;
                if (result_idx == run_last) begin
                    peak_bin   <= next_bin;
                    peak_mag   <= next_mag;
                    detect     <= (next_mag >= threshold);
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                    result_idx <= '0;
                end else begin
                    result_idx <= result_idx + ONE_IDX;
                end
            end

            seq_err <= (seq_err && !err_clr) || req_err || res_err;
        end
    end

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// Bench for goertzel_bin_scheduler: table-driven frames with a frame-result scoreboard,
// plus hand-written sequences for config timing, handshake errors and reset.
module tb_goertzel_bin_scheduler;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cfg_wr_en;
    logic [4:0]  cfg_wr_addr;
    logic [15:0] cfg_sin;
    logic [15:0] cfg_cos;
    logic [4:0]  cfg_num_bins;
    logic [15:0] threshold;
    logic        err_clr;
    logic [4:0]  rd_addr;
    logic [15:0] rd_mag;
    logic [4:0]  peak_bin;
    logic [15:0] peak_mag;
    logic        detect;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        seq_err;

    goertzel_bin_scheduler_if #(.MAG_W(16)) mgr_if ();

    goertzel_bin_scheduler #(.NUM_BINS(16), .BIN_BITS(5), .MAG_W(16)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .mgr          (mgr_if),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_sin      (cfg_sin),
        .cfg_cos      (cfg_cos),
        .cfg_num_bins (cfg_num_bins),
        .threshold    (threshold),
        .err_clr      (err_clr),
        .rd_addr      (rd_addr),
        .rd_mag       (rd_mag),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .detect       (detect),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .seq_err      (seq_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0]  bin;
        logic [15:0] mag;
        logic        det;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [3:0][15:0] mag;
        logic [15:0]      thr;
        logic [4:0]       bin;
        logic [15:0]      pmag;
        logic             det;
    } frame_vec_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] exp_cnt = '0;
    frame_vec_t  vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic frame_vec_t mkvec(input logic [15:0] m0, input logic [15:0] m1,
                                         input logic [15:0] m2, input logic [15:0] m3,
                                         input logic [15:0] thr, input logic [4:0] bin,
                                         input logic [15:0] pmag, input logic det);
        frame_vec_t v;
        v.mag[0] = m0;
        v.mag[1] = m1;
        v.mag[2] = m2;
        v.mag[3] = m3;
        v.thr    = thr;
        v.bin    = bin;
        v.pmag   = pmag;
        v.det    = det;
        return v;
    endfunction

    // Frame results are checked when the DUT pulses frame_done, against what was queued.
    always @(negedge sys_clk) begin
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL frame_done_unexpected: got frame_done=1 frame_cnt=%0d, want no pulse", frame_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("peak_bin", {27'd0, peak_bin}, {27'd0, mon_e.bin});
                check("peak_mag", {16'd0, peak_mag}, {16'd0, mon_e.mag});
                check("detect", {31'd0, detect}, {31'd0, mon_e.det});
                check("frame_cnt", {16'd0, frame_cnt}, {16'd0, mon_e.cnt});
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic expect_frame(input logic [4:0] bin, input logic [15:0] mag, input logic det);
        exp_t e;
        exp_cnt = exp_cnt + 16'd1;
        e.bin = bin;
        e.mag = mag;
        e.det = det;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic wr_coef(input logic [4:0] addr, input logic [15:0] s, input logic [15:0] c);
        cfg_wr_addr = addr;
        cfg_sin     = s;
        cfg_cos     = c;
        cfg_wr_en   = 1'b1;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic check_coef(input int i);
        check($sformatf("sin[%0d]", i), {16'd0, mgr_if.sin_out}, 32'h1000 + i);
        check($sformatf("cos[%0d]", i), {16'd0, mgr_if.cos_out}, 32'h2000 + i);
    endtask

    task automatic run_bin(input int i, input logic [15:0] mag);
        check_coef(i);
        mgr_if.request_trig = 1'b1;
        tick();
        mgr_if.request_trig = 1'b0;
        tick();
        mgr_if.mag_in  = mag;
        mgr_if.mag_rdy = 1'b1;
        tick();
        mgr_if.mag_rdy = 1'b0;
    endtask

    task automatic run_frame4(input frame_vec_t v);
        threshold = v.thr;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expect_frame(v.bin, v.pmag, v.det);
            run_bin(i, v.mag[i]);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_num_runs"}, {27'd0, mgr_if.num_runs}, 32'd0);
        check({tag, "_sin"}, {16'd0, mgr_if.sin_out}, 32'd0);
        check({tag, "_cos"}, {16'd0, mgr_if.cos_out}, 32'd0);
        check({tag, "_peak_bin"}, {27'd0, peak_bin}, 32'd0);
        check({tag, "_peak_mag"}, {16'd0, peak_mag}, 32'd0);
        check({tag, "_detect"}, {31'd0, detect}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
        check({tag, "_seq_err"}, {31'd0, seq_err}, 32'd0);
        check({tag, "_rd_mag"}, {16'd0, rd_mag}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m3 [4];
        vecs[0] = mkvec(16'd100, 16'd900, 16'd900, 16'd50, 16'd800, 5'd1, 16'd900, 1'b1);
        vecs[1] = mkvec(16'd10, 16'd20, 16'd30, 16'd40, 16'd800, 5'd3, 16'd40, 1'b0);
        vecs[2] = mkvec(16'd500, 16'd500, 16'd500, 16'd500, 16'd500, 5'd0, 16'd500, 1'b1);
        vecs[3] = mkvec(16'd7, 16'd3, 16'd9, 16'd2, 16'd10, 5'd2, 16'd9, 1'b0);
        vecs[4] = mkvec(16'hFFFF, 16'd0, 16'hFFFF, 16'd1, 16'hFFFF, 5'd0, 16'hFFFF, 1'b1);
        vecs[5] = mkvec(16'd60, 16'd70, 16'd80, 16'd90, 16'd85, 5'd3, 16'd90, 1'b1);

        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_sin = '0; cfg_cos = '0;
        cfg_num_bins = '0; threshold = '0; err_clr = 1'b0; rd_addr = '0;
        mgr_if.request_trig = 1'b0; mgr_if.mag_rdy = 1'b0; mgr_if.mag_in = '0;
        sys_rst_n = 1'b0;
        tick(); tick(); tick();
        check_reset("reset");
        sys_rst_n = 1'b1;

        for (int i = 0; i < 16; i++) wr_coef(5'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i));
        wr_coef(5'd20, 16'hDEAD, 16'hBEEF);
        cfg_num_bins = 5'd4;
        tick(); tick();
        check("num_runs_4", {27'd0, mgr_if.num_runs}, 32'd4);

        for (int k = 0; k < 5; k++) begin
            run_frame4(vecs[k]);
            check($sformatf("seq_err_frame%0d", k), {31'd0, seq_err}, 32'd0);
            if (k == 0) begin
                rd_addr = 5'd2; tick();
                check("rd_mag_2", {16'd0, rd_mag}, 32'd900);
                rd_addr = 5'd0; tick();
                check("rd_mag_0", {16'd0, rd_mag}, 32'd100);
            end
        end

        // Write-collision on the index being read: old value first, new value one cycle later.
        wr_coef(5'd0, 16'h5555, 16'h6666);
        check("collide_old", {16'd0, mgr_if.sin_out}, 32'h1000);
        tick();
        check("collide_new", {16'd0, mgr_if.sin_out}, 32'h5555);
        wr_coef(5'd0, 16'h1000, 16'h2000);
        tick();

        // Frame length change mid-frame lands only after frame_done.
        threshold = 16'd0;
        run_bin(0, 16'd1);
        cfg_num_bins = 5'd2;
        run_bin(1, 16'd2);
        check("num_runs_midframe", {27'd0, mgr_if.num_runs}, 32'd4);
        run_bin(2, 16'd3);
        expect_frame(5'd3, 16'd4, 1'b1);
        run_bin(3, 16'd4);
        check("num_runs_at_done", {27'd0, mgr_if.num_runs}, 32'd4);
        tick();
        check("num_runs_2", {27'd0, mgr_if.num_runs}, 32'd2);

        threshold = 16'd9;
        run_bin(0, 16'd5);
        expect_frame(5'd1, 16'd8, 1'b0);
        run_bin(1, 16'd8);

        cfg_num_bins = 5'd31;
        tick(); tick();
        check("num_runs_clamp", {27'd0, mgr_if.num_runs}, 32'd16);
        threshold = 16'd1000;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_frame(5'd9, 16'd1000, 1'b1);
            run_bin(i, (i == 9 || i == 12) ? 16'd1000 : 16'(10 * i + 5));
        end
        cfg_num_bins = 5'd4;
        tick(); tick();
        check("num_runs_back4", {27'd0, mgr_if.num_runs}, 32'd4);

        // Handshake violations.
        check("seq_err_clean", {31'd0, seq_err}, 32'd0);
        mgr_if.mag_in = 16'd777; mgr_if.mag_rdy = 1'b1; tick(); mgr_if.mag_rdy = 1'b0;
        check("seq_err_stray_mag", {31'd0, seq_err}, 32'd1);
        rd_addr = 5'd0; tick();
        check("rd_after_stray", {16'd0, rd_mag}, 32'd5);
        err_clr = 1'b1; mgr_if.mag_rdy = 1'b1; tick(); err_clr = 1'b0; mgr_if.mag_rdy = 1'b0;
        check("seq_err_clr_coincide", {31'd0, seq_err}, 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("seq_err_cleared", {31'd0, seq_err}, 32'd0);

        // Result and request in the same cycle are legal.
        m3[0] = 16'd300; m3[1] = 16'd200; m3[2] = 16'd400; m3[3] = 16'd100;
        threshold = 16'd400;
        check_coef(0);
        mgr_if.request_trig = 1'b1; tick(); mgr_if.request_trig = 1'b0; tick();
        for (int i = 1; i < 4; i++) begin
            check_coef(i);
            mgr_if.mag_in = m3[i-1]; mgr_if.mag_rdy = 1'b1; mgr_if.request_trig = 1'b1;
            tick();
            mgr_if.mag_rdy = 1'b0; mgr_if.request_trig = 1'b0;
            tick();
        end
        expect_frame(5'd2, 16'd400, 1'b1);
        mgr_if.mag_in = m3[3]; mgr_if.mag_rdy = 1'b1; tick(); mgr_if.mag_rdy = 1'b0;
        check("seq_err_simultaneous", {31'd0, seq_err}, 32'd0);

        mgr_if.request_trig = 1'b1; tick(); mgr_if.request_trig = 1'b0; tick();
        mgr_if.request_trig = 1'b1; tick(); mgr_if.request_trig = 1'b0;
        check("seq_err_double_req", {31'd0, seq_err}, 32'd1);

        sys_rst_n = 1'b0; tick();
        check_reset("reset_hung");
        sys_rst_n = 1'b1; exp_cnt = '0;
        tick(); tick();
        check("num_runs_after_reset", {27'd0, mgr_if.num_runs}, 32'd4);

        // Reset after 2 of 4 results abandons the frame silently.
        threshold = 16'd0;
        run_bin(0, 16'd11);
        run_bin(1, 16'd22);
        rd_addr = 5'd1;
        sys_rst_n = 1'b0; tick();
        check_reset("reset_mid");
        sys_rst_n = 1'b1;
        tick();
        check("rd_cleared", {16'd0, rd_mag}, 32'd0);
        tick();
        run_frame4(vecs[5]);

        // Zero-length frames: every handshake is a violation and nothing is served.
        cfg_num_bins = 5'd0;
        tick(); tick();
        check("num_runs_0", {27'd0, mgr_if.num_runs}, 32'd0);
        mgr_if.request_trig = 1'b1; tick(); mgr_if.request_trig = 1'b0;
        check("seq_err_req_runs0", {31'd0, seq_err}, 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        mgr_if.mag_rdy = 1'b1; tick(); mgr_if.mag_rdy = 1'b0;
        check("seq_err_mag_runs0", {31'd0, seq_err}, 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        cfg_num_bins = 5'd4;
        tick(); tick();
        run_frame4(vecs[1]);

        tick(); tick(); tick();
        check("frames_pending", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/goertzel_bin_scheduler.md
# goertzel_bin_scheduler

Sequences the Goertzel magnitude manager across a frame of frequency bins. It owns a host-writable sine/cosine coefficient table and serves one coefficient pair per `request_trig`. It collects each per-bin `goertzel_mag`/`mag_rdy` result and reports the peak bin per frame against a detection threshold. It sits between the configuration interface and the Goertzel manager, and drives the manager's `num_runs`, `sin_in` and `cos_in`.

## Interface
- `NUM_BINS`, 16: coefficient/result table depth, 1..31 (limited by the 5-bit run count).
- `BIN_BITS`, 5: index width; must satisfy 2^BIN_BITS > NUM_BINS.
- `MAG_W`, 16: magnitude width.
- `sys_clk` in 1: system clock, all logic on rising edge.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `cfg_wr_en` in 1: write `cfg_sin`/`cfg_cos` to table entry `cfg_wr_addr`.
- `cfg_wr_addr` in BIN_BITS: table index. Writes with an index ≥ NUM_BINS are dropped.
- `cfg_sin`, `cfg_cos` in 16: signed Q2.14 coefficients.
- `cfg_num_bins` in 5: bins per frame; 0 disables; values above NUM_BINS clamp to NUM_BINS.
- `threshold` in MAG_W: unsigned detection threshold.
- `err_clr` in 1: clears `seq_err`.
- `request_trig` in 1: manager coefficient request, 1-cycle pulse.
- `sin_out`, `cos_out` out 16: coefficient pair for the current issue index, to the manager's `sin_in`/`cos_in`.
- `num_runs` out 5: frame length, to the manager.
- `mag_in` in MAG_W: manager `goertzel_mag`.
- `mag_rdy` in 1: manager result strobe, 1-cycle pulse.
- `rd_addr` in BIN_BITS: result readback index.
- `rd_mag` out MAG_W: stored magnitude for `rd_addr`.
- `peak_bin` out BIN_BITS: index of the largest magnitude in the last completed frame.
- `peak_mag` out MAG_W: that magnitude.
- `detect` out 1: `peak_mag >= threshold`, updated at frame completion.
- `frame_done` out 1: 1-cycle pulse at frame completion.
- `frame_cnt` out 16: completed frames, wraps modulo 2^16.
- `seq_err` out 1: sticky handshake-violation flag.

## Operation
- Counters:
  - `issue_idx` counts coefficients served.
  - `result_idx` counts results collected.
  - `outstanding` is set on request and cleared on result.
- Frame idle: `issue_idx == 0`, `result_idx == 0` and `outstanding == 0`.
  - Only while idle is `num_runs` reloaded from the clamped `cfg_num_bins`.
  - A `cfg_num_bins` change mid-frame takes effect at the next frame.
- Coefficient path:
  - Every cycle, `sin_out`/`cos_out` are registered from `table[issue_idx]`.
  - A table write to the index being read in the same cycle returns the old value; the new value appears one cycle later.
- Request handling (`request_trig == 1`):
  - `issue_idx` increments, wrapping to 0 after `num_runs-1`, and `outstanding` is set.
  - A request while `outstanding == 1` sets `seq_err`; it is still served.
- Result handling (`mag_rdy == 1` with `outstanding == 1`):
  - Store `mag_in` to `result[result_idx]` and clear `outstanding`.
  - Update the running peak, compared unsigned. The first bin of a frame always loads. Later bins replace the peak only when strictly greater, so ties keep the lowest index.
  - If `result_idx == num_runs-1`: load `peak_bin`/`peak_mag`/`detect` from the final peak including `mag_in`, pulse `frame_done`, increment `frame_cnt`, and return `result_idx` to 0. Otherwise `result_idx` increments.
- `mag_rdy` with `outstanding == 0` is ignored and sets `seq_err`.
- `request_trig` and `mag_rdy` in the same cycle: the result is processed first, then the request; no error is flagged.
- With `num_runs == 0`, requests and results are ignored and set `seq_err`.
- `seq_err` clears on `err_clr`; it is set in the same cycle if a new violation coincides.
- Reset values:
  - Cleared to 0: all counters, `outstanding`, `num_runs`, `sin_out`, `cos_out`, `rd_mag`, `peak_bin`, `peak_mag`, `detect`, `frame_done`, `frame_cnt`, `seq_err`, and the result table.
  - The coefficient table is not reset.
  - Reset mid-frame abandons the frame without a `frame_done`.

## Timing
- The manager raises `request_trig` after edge k and samples `sin_out`/`cos_out` at edge k+1.
- At edge k+1 the outputs must hold `table[issue_idx]` for the pre-increment index. This holds because `issue_idx` was stable during the preceding cycle.
- The new index's pair appears after edge k+2. Requests must be ≥2 cycles apart, which the manager guarantees.
- `num_runs` becomes valid one cycle after a `cfg_num_bins` write while idle.
- `rd_mag` has a 1-cycle registered latency from `rd_addr`. Reads during a frame return a mix of old- and new-frame values.
- `frame_done`, `peak_*`, `detect` and `frame_cnt` change in the cycle after the final `mag_rdy` edge.

## Test plan
- Reset, then write table[0..3]: `sin = 0x1000 + i`, `cos = 0x2000 + i`; set `cfg_num_bins = 4`.
  - Expect `num_runs = 4`.
  - Four request→mag cycles with the pair sampled at each request edge must read `0x1000/0x2000` through `0x1003/0x2003`.
- Magnitudes 100, 900, 900, 50 with `threshold = 800` → `peak_bin = 1`, `peak_mag = 900`, `detect = 1`, single `frame_done`, `frame_cnt = 1`; `rd_addr = 2` → `rd_mag = 900` after 1 cycle.
- Second frame with magnitudes 10, 20, 30, 40 and `threshold = 800` → `peak_bin = 3`, `detect = 0`, `frame_cnt = 2`; `issue_idx` wraps so the next request serves table[0].
- Write `cfg_num_bins = 2` mid-frame → `num_runs` stays 4 until `frame_done`, then becomes 2. `cfg_num_bins = 31` with `NUM_BINS = 16` → `num_runs = 16`.
- Handshake errors:
  - `mag_rdy` with no request → `seq_err = 1` and `result_idx` unchanged.
  - Two requests with no result → `seq_err = 1`.
  - `err_clr` → 0.
  - Simultaneous `mag_rdy` and `request_trig` → no error.
- Assert `sys_rst_n = 0` for one cycle after 2 of 4 results → all outputs 0, no `frame_done`. The next frame starts at table[0] and the coefficient table retains its contents.
